// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority-vote bit decoding and a first-word-fall-through
// receive FIFO carrying parity/framing error tags per entry.
//
// Ports:
//   rx_clk       oversampling clock (OVS ticks per bit)
//   rst          synchronous active-high reset
//   rx_en        enables detection of new start bits
//   rx           asynchronous serial input, idles high
//   length       data bits per frame (5..8, others treated as 8)
//   parity_en    parity bit present
//   parity_type  1 = even, 0 = odd
//   stop2        two stop bits
//   rd_data      FIFO head data, right-justified
//   rd_perr      parity error tag of head entry
//   rd_ferr      framing error tag of head entry
//   rd_valid     FIFO not empty
//   rd_ready     pops the head when rd_valid is set
//   fifo_count   occupied entries
//   overrun      sticky, set when a frame is dropped on a full FIFO
//   ovr_clr      clears overrun (a simultaneous new overrun wins)
//   break_det    one-cycle pulse on a break frame
//   busy         receiver not idle
module uart_rx_fifo #(
  parameter int unsigned OVS        = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        rx_clk,
  input  logic                        rst,
  input  logic                        rx_en,
  input  logic                        rx,
  input  logic [3:0]                  length,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        stop2,
  output logic [7:0]                  rd_data,
  output logic                        rd_perr,
  output logic                        rd_ferr,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        break_det,
  output logic                        busy
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TickLast = TW'(OVS - 1);
  localparam logic [TW-1:0] TickDec  = TW'(OVS / 2);
  localparam logic [TW-1:0] TickS0   = TW'(OVS / 2 - 2);
  localparam logic [TW-1:0] TickS1   = TW'(OVS / 2 - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StHold
  } state_e;

  // Synchronizer
  logic rx_meta, rxs;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM state
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    samp_q, samp_d;
  logic [3:0]    len_q, len_d;
  logic          pen_q, pen_d;
  logic          ptype_q, ptype_d;
  logic          two_q, two_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          s1z_q, s1z_d;   // first stop bit sampled as 0
  logic          pz_q, pz_d;     // parity bit sampled as 0 (or absent)
  logic          brk_q;

  logic       bit_val;
  logic [7:0] data_rj;
  logic       exp_par;
  logic       frame_done;
  logic       done_ferr;
  logic       brk_now;

  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  // Bits enter at the MSB, so a short frame sits left-aligned until shifted down.
  assign data_rj = shift_q >> (4'd8 - len_q);
  assign exp_par = ptype_q ? ^data_rj : ~^data_rj;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    len_d      = len_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    two_d      = two_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    s1z_d      = s1z_q;
    pz_d       = pz_q;
    frame_done = 1'b0;
    done_ferr  = ferr_q;
    brk_now    = 1'b0;

    if (state_q != StIdle && state_q != StHold) begin
      tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
      if (tick_q == TickS0) samp_d[0] = rxs;
      if (tick_q == TickS1) samp_d[1] = rxs;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_en && !rxs) begin
          state_d   = StStart;
          tick_d    = '0;
          len_d     = (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;
          pen_d     = parity_en;
          ptype_d   = parity_type;
          two_d     = stop2;
          bit_cnt_d = '0;
          shift_d   = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          s1z_d     = 1'b0;
          pz_d      = 1'b1;
        end
      end
      StStart: begin
        if (tick_q == TickDec && bit_val) begin
          state_d = StIdle;
          tick_d  = '0;
        end else if (tick_q == TickLast) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick_q == TickDec) shift_d = {bit_val, shift_q[7:1]};
        if (tick_q == TickLast) begin
          if ({1'b0, bit_cnt_q} == len_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? StParity : StStop1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick_q == TickDec) begin
          perr_d = (bit_val != exp_par);
          pz_d   = ~bit_val;
        end
        if (tick_q == TickLast) state_d = StStop1;
      end
      StStop1: begin
        if (tick_q == TickDec) begin
          if (two_q) begin
            ferr_d = ferr_q | ~bit_val;
            s1z_d  = ~bit_val;
          end else begin
            frame_done = 1'b1;
            done_ferr  = ferr_q | ~bit_val;
            brk_now    = (data_rj == 8'd0) & pz_q & ~bit_val;
            state_d    = done_ferr ? StHold : StIdle;
            tick_d     = '0;
          end
        end else if (tick_q == TickLast) begin
          state_d = StStop2;
        end
      end
      StStop2: begin
        if (tick_q == TickDec) begin
          frame_done = 1'b1;
          done_ferr  = ferr_q | ~bit_val;
          brk_now    = (data_rj == 8'd0) & pz_q & s1z_q;
          state_d    = done_ferr ? StHold : StIdle;
          tick_d     = '0;
        end
      end
      StHold: begin
        // Keep a stuck-low line from being re-detected as a stream of start bits.
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      len_q     <= 4'd8;
      pen_q     <= 1'b0;
      ptype_q   <= 1'b0;
      two_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      s1z_q     <= 1'b0;
      pz_q      <= 1'b1;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      len_q     <= len_d;
      pen_q     <= pen_d;
      ptype_q   <= ptype_d;
      two_q     <= two_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      s1z_q     <= s1z_d;
      pz_q      <= pz_d;
      brk_q     <= frame_done & brk_now;
    end
  end

  assign busy      = (state_q != StIdle);
  assign break_det = brk_q;

  // Receive FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          ovr_q;
  logic          full, pop, push, ovr_set;

  assign full    = (count_q == (PW + 1)'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign pop     = rd_valid & rd_ready;
  assign push    = frame_done & (~full | pop);
  assign ovr_set = frame_done & full & ~pop;

  always_ff @(posedge rx_clk) begin
    if (push) mem[wr_ptr_q] <= {perr_q, done_ferr, data_rj};
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  logic [9:0] head;
  assign head       = mem[rd_ptr_q];
  assign rd_data    = rd_valid ? head[7:0] : 8'd0;
  assign rd_ferr    = rd_valid ? head[8] : 1'b0;
  assign rd_perr    = rd_valid ? head[9] : 1'b0;
  assign fifo_count = count_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter OVS, default 16: rx_clk ticks per bit; even; range 8..32.
REQ-002 Parameter FIFO_DEPTH, default 8: receive FIFO entries; power of 2, at least 2.
REQ-003 Reset is rst, synchronous, active-high; clock is rx_clk.
REQ-004 Port rx_clk, input, 1: oversampling clock.
REQ-005 Port rst, input, 1: reset.
REQ-006 Port rx_en, input, 1: enables detection of new start bits.
REQ-007 Port rx, input, 1: asynchronous serial line; idles high.
REQ-008 Port length, input, 4: data bits per frame, 5..8.
REQ-009 Port parity_en, input, 1: parity bit present.
REQ-010 Port parity_type, input, 1: 1 = even parity (bit = XOR of data bits); 0 = odd parity.
REQ-011 Port stop2, input, 1: two stop bits.
REQ-012 Port rd_data, output, 8: FIFO head data, right-justified, unused upper bits 0.
REQ-013 Port rd_perr / rd_ferr, output, 1 each: parity and framing error tags of the head entry.
REQ-014 Port rd_valid, output, 1: FIFO not empty.
REQ-015 Port rd_ready, input, 1: pops the head when rd_valid is 1.
REQ-016 Port fifo_count, output, $clog2(FIFO_DEPTH)+1: number of occupied entries.
REQ-017 Port overrun, output, 1: sticky flag, set when a frame is dropped because the FIFO is full.
REQ-018 Port ovr_clr, input, 1: clears overrun.
REQ-019 Port break_det, output, 1: one-cycle pulse on a break frame.
REQ-020 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-021 rx passes through a 2-flop synchronizer; all timing below refers to the synchronized signal rxs.
REQ-022 FSM states are IDLE, START, DATA, PARITY, STOP1, STOP2, HOLD; the per-bit tick counter runs 0..OVS-1.
REQ-023 IDLE: when rx_en=1 and rxs=0, go to START and latch length, parity_en, parity_type and stop2 for the whole frame.
REQ-024 Bit value is the majority of rxs at ticks OVS/2-2, OVS/2-1 and OVS/2; the decision is taken at tick OVS/2.
REQ-025 START: if the bit value is 1, return to IDLE with no FIFO write; otherwise go to DATA at tick OVS-1.
REQ-026 DATA: shift bits LSB first; after the latched length bits go to PARITY if parity_en, else to STOP1.
REQ-027 A length value outside 5..8 is treated as 8.
REQ-028 PARITY: the perr tag is 1 when the bit value differs from the expected parity.
REQ-029 STOP1 / STOP2: a bit value of 0 sets the ferr tag; go to STOP2 only when stop2=1.
REQ-030 The frame is completed at the decision tick of the last stop bit.
- The FIFO write occurs on the next rx_clk edge.
- The FSM then returns to IDLE, or to HOLD when ferr=1.
REQ-031 HOLD: wait until rxs=1, then go to IDLE; this prevents a stuck-low line from being re-detected as start bits.
REQ-032 Break frame: all data bits 0, parity bit 0 if present, and first stop bit 0.
- Pulse break_det for 1 cycle.
- Still write the entry with ferr=1.
REQ-033 rx_en=0 during a frame: the frame completes normally; only new start detection is gated.
REQ-034 FIFO is first-word-fall-through.
- rd_data, rd_perr and rd_ferr are valid whenever rd_valid=1.
- A pop occurs on rd_valid & rd_ready; rd_ready while empty has no effect.
REQ-035 Write while full with no pop in the same cycle: the frame is discarded and overrun is set; FIFO contents are unchanged.
REQ-036 Write while full with a pop in the same cycle: the write is accepted and fifo_count is unchanged.
REQ-037 Simultaneous write and pop when not full: fifo_count is unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-038 ovr_clr in the same cycle as a new overrun: set wins.
REQ-039 Latency: rd_valid rises 1 cycle after the last stop-bit decision tick when the FIFO was empty.

Reset
REQ-040 rst clears the following, including mid-frame:
- FSM to IDLE, counters to 0, FIFO pointers to 0.
- fifo_count=0, rd_valid=0, overrun=0, break_det=0, busy=0.
- rd_data, rd_perr and rd_ferr to 0.
- Synchronizer flops to 1.
REQ-041 No partial frame is written after reset; the next start bit is decoded cleanly.

Verification (OVS=16, FIFO_DEPTH=4)
REQ-042 length=8, no parity, 1 stop, send 0xA5 -> rd_data=0xA5, perr=0, ferr=0, fifo_count=1; rd_ready pops it -> fifo_count=0.
REQ-043 length=7, parity_en=1, parity_type=1, send 0x35 with parity bit 1 (correct bit is 0) -> rd_data=0x35, rd_perr=1; the same frame with the correct bit gives rd_perr=0.
REQ-044 rx low for 4 bit-ticks then high -> no write, busy returns to 0, fifo_count=0.
REQ-045 Five frames 0x01..0x05 with rd_ready=0 -> fifo_count=4, overrun=1, pops yield 0x01..0x04; ovr_clr -> overrun=0.
REQ-046 stop2=1 with second stop bit 0 -> ferr=1; frame of all 0s with stop 0 -> break_det pulse, entry 0x00 with ferr=1, FSM holds in HOLD until rx=1.
REQ-047 rst asserted at mid-DATA of a frame -> all outputs at reset values, no write; the following frame 0x5A is received correctly.
